// File: rtl/l3_pkg.sv
// Shared definitions for the L3 snoop responder: bus/MESIF/result codes,
// FSM states, and the snoop decision function.
package l3_pkg;

   typedef enum logic [2:0] {
      OP_READ  = 3'd1,
      OP_WRITE = 3'd2,
      OP_INVAL = 3'd3,
      OP_RFO   = 3'd4,
      OP_NOP   = 3'd5
   } bus_op_e;

   typedef enum logic [2:0] {
      MS_M = 3'd0,
      MS_E = 3'd1,
      MS_S = 3'd2,
      MS_I = 3'd3,
      MS_F = 3'd4
   } mesif_e;

   typedef enum logic [1:0] {
      RES_HIT   = 2'd0,
      RES_HITM  = 2'd1,
      RES_NOHIT = 2'd2
   } res_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_RESPOND,
      ST_WB
   } fsm_e;

   typedef struct packed {
      logic [2:0] new_state;
      logic [1:0] res_code;
      logic       err;
   } snp_result_t;

   // Misses and unknown state codes leave the line untouched and answer NOHIT.
   function automatic snp_result_t next_state_and_result(input logic [2:0] op,
                                                         input logic       hit,
                                                         input logic [2:0] state);
      snp_result_t r;
      logic        w_present;
      r.new_state = state;
      r.res_code  = RES_NOHIT;
      r.err       = 1'b0;
      w_present   = hit && ((state == MS_M) || (state == MS_E) ||
                            (state == MS_S) || (state == MS_F));
      if (w_present) begin
         case (op)
            OP_READ: begin
               r.new_state = MS_S;
               r.res_code  = (state == MS_M) ? RES_HITM : RES_HIT;
            end
            OP_RFO: begin
               r.new_state = MS_I;
               r.res_code  = (state == MS_M) ? RES_HITM : RES_HIT;
            end
            OP_INVAL: begin
               if ((state == MS_S) || (state == MS_F)) r.new_state = MS_I;
               else                                    r.err       = 1'b1;
            end
            OP_WRITE: r.err = 1'b1;
            default: ;
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/l3_snoop_responder_sat_counter.sv
// Saturating statistics counter with synchronous clear that overrides increment.
module sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      r_cnt <= '0;
      else if (clr)                    r_cnt <= '0;
      else if (inc && (r_cnt != '1))   r_cnt <= r_cnt + 1'b1;
   end

   assign cnt = r_cnt;

endmodule

// File: rtl/l3_snoop_responder.sv
// L3 snoop responder: accepts bus snoops, looks up the tag/MESIF array,
// answers HIT/HITM/NOHIT, commits downgrades and issues HITM writebacks.
module l3_snoop_responder
   import l3_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned WAY_W  = 4,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              snp_valid,
   output logic              snp_ready,
   input  logic [2:0]        snp_op,
   input  logic [ADDR_W-1:0] snp_addr,
   output logic              lk_req,
   output logic [ADDR_W-1:0] lk_addr,
   input  logic              lk_hit,
   input  logic [WAY_W-1:0]  lk_way,
   input  logic [2:0]        lk_state,
   output logic              upd_en,
   output logic [ADDR_W-1:0] upd_addr,
   output logic [WAY_W-1:0]  upd_way,
   output logic [2:0]        upd_state,
   output logic              res_valid,
   output logic [1:0]        res_code,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [2:0]        wb_op,
   output logic [ADDR_W-1:0] wb_addr,
   output logic              proto_err,
   input  logic              clr,
   output logic [CNT_W-1:0]  cnt_snoop,
   output logic [CNT_W-1:0]  cnt_hit,
   output logic [CNT_W-1:0]  cnt_hitm
);

   fsm_e              r_state;
   logic [2:0]        r_op;
   logic [ADDR_W-1:0] r_addr;

   snp_result_t       w_res;
   logic              w_respond;

   assign w_respond = (r_state == ST_RESPOND);
   assign w_res     = next_state_and_result(r_op, lk_hit, lk_state);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_op    <= '0;
         r_addr  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (snp_valid) begin
                  r_op    <= snp_op;
                  r_addr  <= snp_addr;
                  r_state <= ST_LOOKUP;
               end
            end
            ST_LOOKUP:  r_state <= ST_RESPOND;
            ST_RESPOND: r_state <= (w_res.res_code == RES_HITM) ? ST_WB : ST_IDLE;
            ST_WB:      if (wb_ready) r_state <= ST_IDLE;
            default:    r_state <= ST_IDLE;
         endcase
      end
   end

   assign snp_ready = (r_state == ST_IDLE);
   assign lk_req    = (r_state == ST_LOOKUP);
   assign lk_addr   = lk_req ? r_addr : '0;

   // Lookup data arrives in the RESPOND cycle, so the result path is decoded
   // from it directly rather than registered.
   assign res_valid = w_respond;
   assign res_code  = w_respond ? w_res.res_code : RES_NOHIT;
   assign proto_err = w_respond && w_res.err;
   assign upd_en    = w_respond && (w_res.new_state != lk_state);
   assign upd_addr  = upd_en ? r_addr : '0;
   assign upd_way   = upd_en ? lk_way : '0;
   assign upd_state = upd_en ? w_res.new_state : 3'd0;

   assign wb_valid  = (r_state == ST_WB);
   assign wb_op     = wb_valid ? OP_WRITE : 3'd0;
   assign wb_addr   = wb_valid ? r_addr : '0;

   sat_counter #(.CNT_W(CNT_W)) u_cnt_snoop (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_respond),
      .clr   (clr),
      .cnt   (cnt_snoop)
   );

   sat_counter #(.CNT_W(CNT_W)) u_cnt_hit (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_respond && (w_res.res_code == RES_HIT)),
      .clr   (clr),
      .cnt   (cnt_hit)
   );

   sat_counter #(.CNT_W(CNT_W)) u_cnt_hitm (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_respond && (w_res.res_code == RES_HITM)),
      .clr   (clr),
      .cnt   (cnt_hitm)
   );

endmodule

// File: tb/tb_l3_snoop_responder.sv
// Directed self-checking bench for l3_snoop_responder (CNT_W=4 to reach saturation).
module tb_l3_snoop_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        snp_valid;
   logic        snp_ready;
   logic [2:0]  snp_op;
   logic [31:0] snp_addr;
   logic        lk_req;
   logic [31:0] lk_addr;
   logic        lk_hit;
   logic [3:0]  lk_way;
   logic [2:0]  lk_state;
   logic        upd_en;
   logic [31:0] upd_addr;
   logic [3:0]  upd_way;
   logic [2:0]  upd_state;
   logic        res_valid;
   logic [1:0]  res_code;
   logic        wb_valid;
   logic        wb_ready;
   logic [2:0]  wb_op;
   logic [31:0] wb_addr;
   logic        proto_err;
   logic        clr;
   logic [3:0]  cnt_snoop;
   logic [3:0]  cnt_hit;
   logic [3:0]  cnt_hitm;

   int n_tests = 0;
   int n_fail  = 0;

   // Values captured during a snoop transaction
   logic        c_lk_req, c_rv_early, c_res_valid, c_upd_en, c_err;
   logic [31:0] c_lk_addr, c_upd_addr;
   logic [1:0]  c_code;
   logic [3:0]  c_upd_way;
   logic [2:0]  c_upd_state;

   always #5 clk = ~clk;

   l3_snoop_responder #(.ADDR_W(32), .WAY_W(4), .CNT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .snp_valid (snp_valid),
      .snp_ready (snp_ready),
      .snp_op    (snp_op),
      .snp_addr  (snp_addr),
      .lk_req    (lk_req),
      .lk_addr   (lk_addr),
      .lk_hit    (lk_hit),
      .lk_way    (lk_way),
      .lk_state  (lk_state),
      .upd_en    (upd_en),
      .upd_addr  (upd_addr),
      .upd_way   (upd_way),
      .upd_state (upd_state),
      .res_valid (res_valid),
      .res_code  (res_code),
      .wb_valid  (wb_valid),
      .wb_ready  (wb_ready),
      .wb_op     (wb_op),
      .wb_addr   (wb_addr),
      .proto_err (proto_err),
      .clr       (clr),
      .cnt_snoop (cnt_snoop),
      .cnt_hit   (cnt_hit),
      .cnt_hitm  (cnt_hitm)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one snoop; returns #1 after the edge that ends RESPOND.
   task automatic do_snoop(input logic [2:0] op, input logic [31:0] addr, input bit clr_at_resp);
      int unsigned w;
      w = 0;
      while (snp_ready !== 1'b1 && w < 20) begin
         step();
         w++;
      end
      if (snp_ready !== 1'b1) begin
         n_tests++; n_fail++;
         $display("FAIL snp_ready_timeout got %b exp 1", snp_ready);
      end
      snp_valid = 1'b1; snp_op = op; snp_addr = addr;
      step();
      snp_valid = 1'b0; snp_op = 3'd0; snp_addr = 32'd0;
      c_lk_req = lk_req; c_lk_addr = lk_addr; c_rv_early = res_valid;
      step();
      c_res_valid = res_valid; c_code = res_code; c_upd_en = upd_en;
      c_upd_addr = upd_addr; c_upd_way = upd_way; c_upd_state = upd_state; c_err = proto_err;
      if (clr_at_resp) clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   task automatic test_reset();
      n_tests++;
      if ({snp_ready, res_valid, res_code, wb_valid, lk_req, upd_en, proto_err} !== 8'b1_0_10_0_0_0_0) begin
         n_fail++;
         $display("FAIL reset_outputs got rdy=%b rv=%b code=%0d wb=%b lk=%b upd=%b err=%b exp 1 0 2 0 0 0 0",
                  snp_ready, res_valid, res_code, wb_valid, lk_req, upd_en, proto_err);
      end
      n_tests++;
      if ({cnt_snoop, cnt_hit, cnt_hitm} !== 12'd0) begin
         n_fail++;
         $display("FAIL reset_counters got %0d %0d %0d exp 0 0 0", cnt_snoop, cnt_hit, cnt_hitm);
      end
   endtask

   task automatic test_read_hit();
      lk_hit = 1'b1; lk_way = 4'd5; lk_state = 3'd1;
      do_snoop(3'd1, 32'h1000, 1'b0);
      n_tests++;
      if ({c_lk_req, c_lk_addr, c_rv_early} !== {1'b1, 32'h1000, 1'b0}) begin
         n_fail++;
         $display("FAIL read_lookup got req=%b addr=%h rv=%b exp 1 00001000 0", c_lk_req, c_lk_addr, c_rv_early);
      end
      n_tests++;
      if ({c_res_valid, c_code, c_err} !== {1'b1, 2'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL read_result got rv=%b code=%0d err=%b exp 1 0 0", c_res_valid, c_code, c_err);
      end
      n_tests++;
      if ({c_upd_en, c_upd_addr, c_upd_way, c_upd_state} !== {1'b1, 32'h1000, 4'd5, 3'd2}) begin
         n_fail++;
         $display("FAIL read_update got en=%b addr=%h way=%0d st=%0d exp 1 00001000 5 2",
                  c_upd_en, c_upd_addr, c_upd_way, c_upd_state);
      end
      n_tests++;
      if ({cnt_snoop, cnt_hit, cnt_hitm, snp_ready} !== {4'd1, 4'd1, 4'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL read_counters got snoop=%0d hit=%0d hitm=%0d rdy=%b exp 1 1 0 1",
                  cnt_snoop, cnt_hit, cnt_hitm, snp_ready);
      end
      // Back-to-back: S stays S, still a HIT, no state write
      lk_state = 3'd2;
      do_snoop(3'd1, 32'h1040, 1'b0);
      n_tests++;
      if ({c_code, c_upd_en, c_lk_addr} !== {2'd0, 1'b0, 32'h1040}) begin
         n_fail++;
         $display("FAIL read_shared got code=%0d upd=%b addr=%h exp 0 0 00001040", c_code, c_upd_en, c_lk_addr);
      end
      n_tests++;
      if ({cnt_snoop, cnt_hit} !== {4'd2, 4'd2}) begin
         n_fail++;
         $display("FAIL read_shared_cnt got snoop=%0d hit=%0d exp 2 2", cnt_snoop, cnt_hit);
      end
   endtask

   task automatic test_rfo_wb();
      lk_hit = 1'b1; lk_way = 4'd3; lk_state = 3'd0; wb_ready = 1'b0;
      do_snoop(3'd4, 32'h2040, 1'b0);
      n_tests++;
      if ({c_code, c_upd_en, c_upd_way, c_upd_state} !== {2'd1, 1'b1, 4'd3, 3'd3}) begin
         n_fail++;
         $display("FAIL rfo_result got code=%0d upd=%b way=%0d st=%0d exp 1 1 3 3",
                  c_code, c_upd_en, c_upd_way, c_upd_state);
      end
      n_tests++;
      if ({cnt_snoop, cnt_hit, cnt_hitm} !== {4'd3, 4'd2, 4'd1}) begin
         n_fail++;
         $display("FAIL rfo_counters got %0d %0d %0d exp 3 2 1", cnt_snoop, cnt_hit, cnt_hitm);
      end
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if ({wb_valid, wb_op, wb_addr, snp_ready} !== {1'b1, 3'd2, 32'h2040, 1'b0}) begin
            n_fail++;
            $display("FAIL wb_hold[%0d] got v=%b op=%0d addr=%h rdy=%b exp 1 2 00002040 0",
                     i, wb_valid, wb_op, wb_addr, snp_ready);
         end
         step();
      end
      wb_ready = 1'b1;
      n_tests++;
      if (wb_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL wb_handshake got v=%b exp 1", wb_valid);
      end
      step();
      wb_ready = 1'b0;
      n_tests++;
      if ({wb_valid, wb_op, snp_ready} !== {1'b0, 3'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL wb_release got v=%b op=%0d rdy=%b exp 0 0 1", wb_valid, wb_op, snp_ready);
      end
   endtask

   task automatic test_inval_write();
      lk_hit = 1'b1; lk_way = 4'd7; lk_state = 3'd0;
      do_snoop(3'd3, 32'h3000, 1'b0);
      n_tests++;
      if ({c_err, c_upd_en, c_code} !== {1'b1, 1'b0, 2'd2}) begin
         n_fail++;
         $display("FAIL inval_m got err=%b upd=%b code=%0d exp 1 0 2", c_err, c_upd_en, c_code);
      end
      n_tests++;
      if ({proto_err, snp_ready, cnt_snoop, cnt_hit, cnt_hitm} !== {1'b0, 1'b1, 4'd4, 4'd2, 4'd1}) begin
         n_fail++;
         $display("FAIL inval_m_after got err=%b rdy=%b cnt=%0d/%0d/%0d exp 0 1 4/2/1",
                  proto_err, snp_ready, cnt_snoop, cnt_hit, cnt_hitm);
      end
      lk_state = 3'd2;
      do_snoop(3'd3, 32'h3040, 1'b0);
      n_tests++;
      if ({c_err, c_upd_en, c_upd_state, c_code} !== {1'b0, 1'b1, 3'd3, 2'd2}) begin
         n_fail++;
         $display("FAIL inval_s got err=%b upd=%b st=%0d code=%0d exp 0 1 3 2", c_err, c_upd_en, c_upd_state, c_code);
      end
      lk_state = 3'd1;
      do_snoop(3'd2, 32'h3080, 1'b0);
      n_tests++;
      if ({c_err, c_upd_en, c_code} !== {1'b1, 1'b0, 2'd2}) begin
         n_fail++;
         $display("FAIL write_hit got err=%b upd=%b code=%0d exp 1 0 2", c_err, c_upd_en, c_code);
      end
   endtask

   task automatic test_miss_sweep();
      clr = 1'b1; step(); clr = 1'b0;
      n_tests++;
      if ({cnt_snoop, cnt_hit, cnt_hitm} !== 12'd0) begin
         n_fail++;
         $display("FAIL clr_idle got %0d %0d %0d exp 0 0 0", cnt_snoop, cnt_hit, cnt_hitm);
      end
      lk_hit = 1'b0; lk_way = 4'd9; lk_state = 3'd0;
      for (int op = 1; op <= 5; op++) begin
         do_snoop(3'(op), 32'h4000 + 32'(op), 1'b0);
         n_tests++;
         if ({c_code, c_upd_en, c_err, c_lk_req} !== {2'd2, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL miss_op%0d got code=%0d upd=%b err=%b lk=%b exp 2 0 0 1",
                     op, c_code, c_upd_en, c_err, c_lk_req);
         end
      end
      n_tests++;
      if ({cnt_snoop, cnt_hit, cnt_hitm} !== {4'd5, 4'd0, 4'd0}) begin
         n_fail++;
         $display("FAIL miss_counters got %0d %0d %0d exp 5 0 0", cnt_snoop, cnt_hit, cnt_hitm);
      end
      lk_hit = 1'b1; lk_state = 3'd3;
      do_snoop(3'd4, 32'h4100, 1'b0);
      n_tests++;
      if ({c_code, c_upd_en, cnt_snoop, cnt_hit} !== {2'd2, 1'b0, 4'd6, 4'd0}) begin
         n_fail++;
         $display("FAIL miss_invalid got code=%0d upd=%b snoop=%0d hit=%0d exp 2 0 6 0",
                  c_code, c_upd_en, cnt_snoop, cnt_hit);
      end
   endtask

   task automatic test_saturation();
      clr = 1'b1; step(); clr = 1'b0;
      lk_hit = 1'b1; lk_way = 4'd1; lk_state = 3'd2;
      for (int i = 0; i < 16; i++) do_snoop(3'd1, 32'h5000, 1'b0);
      n_tests++;
      if ({cnt_snoop, cnt_hit, cnt_hitm} !== {4'd15, 4'd15, 4'd0}) begin
         n_fail++;
         $display("FAIL saturate got %0d %0d %0d exp 15 15 0", cnt_snoop, cnt_hit, cnt_hitm);
      end
      do_snoop(3'd1, 32'h5000, 1'b1);
      n_tests++;
      if ({cnt_snoop, cnt_hit, cnt_hitm} !== 12'd0) begin
         n_fail++;
         $display("FAIL clr_wins got %0d %0d %0d exp 0 0 0", cnt_snoop, cnt_hit, cnt_hitm);
      end
      do_snoop(3'd1, 32'h5000, 1'b0);
      n_tests++;
      if ({cnt_snoop, cnt_hit} !== {4'd1, 4'd1}) begin
         n_fail++;
         $display("FAIL post_clr got snoop=%0d hit=%0d exp 1 1", cnt_snoop, cnt_hit);
      end
   endtask

   task automatic test_reset_mid_wb();
      lk_hit = 1'b1; lk_way = 4'd2; lk_state = 3'd0; wb_ready = 1'b0;
      do_snoop(3'd1, 32'h6000, 1'b0);
      n_tests++;
      if ({wb_valid, cnt_hitm} !== {1'b1, 4'd1}) begin
         n_fail++;
         $display("FAIL pre_reset_wb got v=%b hitm=%0d exp 1 1", wb_valid, cnt_hitm);
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({wb_valid, snp_ready, wb_addr} !== {1'b0, 1'b1, 32'h0}) begin
         n_fail++;
         $display("FAIL reset_mid_wb got v=%b rdy=%b addr=%h exp 0 1 00000000", wb_valid, snp_ready, wb_addr);
      end
      #4 rst_n = 1'b1;
      step();
      n_tests++;
      if ({snp_ready, res_code, cnt_snoop, cnt_hit, cnt_hitm} !== {1'b1, 2'd2, 12'd0}) begin
         n_fail++;
         $display("FAIL after_reset got rdy=%b code=%0d cnt=%0d/%0d/%0d exp 1 2 0/0/0",
                  snp_ready, res_code, cnt_snoop, cnt_hit, cnt_hitm);
      end
   endtask

   initial begin
      rst_n = 1'b0; snp_valid = 1'b0; snp_op = 3'd0; snp_addr = 32'd0;
      lk_hit = 1'b0; lk_way = 4'd0; lk_state = 3'd3; wb_ready = 1'b0; clr = 1'b0;
      step();
      test_reset();
      step();
      rst_n = 1'b1;
      step();
      test_reset();
      test_read_hit();
      test_rfo_wb();
      test_inval_write();
      test_miss_sweep();
      test_saturation();
      test_reset_mid_wb();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/l3_snoop_responder.md
Name: l3_snoop_responder

Overview:
- Responding end of the L3 snoop/bus protocol: accepts snooped bus operations (READ, WRITE, INVALIDATE, RFO) that other caches issue on the shared bus.
- Looks up the local L3 tag/MESIF store and returns the snoop result (HIT/HITM/NOHIT).
- Commits the MESIF state downgrade and, on HITM, issues the dirty-line writeback (bus WRITE).
- Sits between the bus snoop port and the L3 tag/state array; the L3 request-side controller is the initiator counterpart.

Parameters:
- ADDR_W, 32, snooped physical address width
- WAY_W, 4, way index width (16-way L3)
- CNT_W, 32, statistics counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- snp_valid  in  1  snooped op present
- snp_ready  out  1  responder can accept an op
- snp_op  in  3  bus op: READ=1 WRITE=2 INVALIDATE=3 RFO=4 NOP=5
- snp_addr  in  ADDR_W  snooped address
- lk_req  out  1  tag/state lookup request
- lk_addr  out  ADDR_W  lookup address
- lk_hit  in  1  valid tag match; sampled one cycle after lk_req
- lk_way  in  WAY_W  matching way
- lk_state  in  3  MESIF state: M=0 E=1 S=2 I=3 F=4
- upd_en  out  1  state write strobe
- upd_addr  out  ADDR_W  line to update
- upd_way  out  WAY_W  way to update
- upd_state  out  3  new MESIF state
- res_valid  out  1  snoop result strobe
- res_code  out  2  HIT=0 HITM=1 NOHIT=2
- wb_valid  out  1  writeback bus request
- wb_ready  in  1  bus accepts writeback
- wb_op  out  3  always WRITE(2) while wb_valid is high
- wb_addr  out  ADDR_W  writeback line address
- proto_err  out  1  one-cycle pulse on an illegal state/op combination
- clr  in  1  synchronous clear of the counters
- cnt_snoop, cnt_hit, cnt_hitm  out  CNT_W each  statistics counters

Behaviour:
- Reset (asynchronous, rst_n=0): FSM returns to IDLE; every output is 0 except snp_ready=1 and res_code=NOHIT(2); counters are 0. Any pending writeback is dropped.
- FSM states: IDLE, LOOKUP, RESPOND, WB.
- IDLE: snp_ready=1. On snp_valid&&snp_ready, register op and addr and go to LOOKUP.
- LOOKUP: lk_req=1 for exactly 1 cycle; lk_addr holds the registered address. Go to RESPOND.
- RESPOND: sample lk_*. Drive res_valid=1 for 1 cycle. Increment cnt_snoop, plus cnt_hit or cnt_hitm per res_code. Drive upd_en only when the state changes. Go to WB if HITM, else IDLE.
- Latency: res_valid asserts 2 cycles after the accept edge. The next accept is possible 3 cycles after the previous one when there is no writeback.
- Miss (lk_hit=0, or lk_state=I): NOHIT, no update, for every op.
- READ: M->S, HITM. E->S, HIT. F->S, HIT. S stays S, HIT.
- RFO: M->I, HITM. E/S/F->I, HIT.
- INVALIDATE: S/F->I, NOHIT. M/E: proto_err, state unchanged, NOHIT.
- WRITE: NOHIT, no update; a local hit raises proto_err.
- NOP or an undefined op: NOHIT, no lookup side effects (lk_req still pulses).
- WB: wb_valid held high with wb_addr stable until wb_valid&&wb_ready, then return to IDLE. snp_ready=0 for the whole state.
- Counters saturate at all-ones. If clr and an increment occur in the same cycle, clr wins.
- upd_en and res_valid coincide in the RESPOND cycle. upd_addr/upd_way are valid only while upd_en=1.

Decomposition:
- Shared package l3_pkg holds:
  - bus op codes
  - MESIF state codes
  - snoop result codes
  - FSM state enum
  - a pure function next_state_and_result(op, hit, state) returning {new_state, res_code, err}.
- One sub-module is natural: sat_counter (CNT_W, inc, clr), instantiated three times.

Test Plan:
- Reset mid-WB: assert rst_n=0 while wb_valid=1 -> wb_valid=0 immediately; after release snp_ready=1 and all counters=0.
- READ to addr 0x1000, lookup returns hit way 5 in E -> res_valid at cycle 2 with res_code=HIT(0); upd_en=1, upd_way=5, upd_state=S(2); cnt_hit=1.
- RFO to addr 0x2040, lookup returns hit in M, wb_ready held low 4 cycles -> res_code=HITM(1), upd_state=I(3). wb_valid=1, wb_op=2, wb_addr=0x2040 stay stable for 4 cycles, drop the cycle after wb_ready=1; snp_ready stays 0 until then.
- INVALIDATE, lookup returns hit in M -> proto_err pulses once, upd_en=0, res_code=NOHIT(2).
- Miss sweep: ops 1..5 each with lk_hit=0 -> five NOHIT responses, upd_en never asserted, cnt_snoop=5.
- Counter saturation (CNT_W=4): 16 READ hits -> cnt_hit stays at 15. clr together with a RESPOND cycle -> counters read 0 afterwards.
